lsu_unit: RTL and testbench

Load/store unit in the memory stage, directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, together with store data, funct3 and the destination register. It drives a word-organised data memory through a request/grant/read-valid handshake, stalls the pipeline while a transaction is outstanding, and returns sign- or zero-extended load data for writeback.

---
 rtl/lsu_unit_if.sv | 31 +++
 rtl/lsu_unit.sv | 159 +++++++++++++++
 tb/tb_lsu_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_unit_if.sv
// Memory-side bus of the load/store unit: one request channel (req/gnt)
// plus a read-return channel (rvalid/rdata).
//
// Handshake: the master raises MemReq_o with MemWe_o/MemAddr_o/MemBe_o/MemWData_o
// and keeps all of them stable until the slave answers with MemGnt_i in the
// same cycle; the transfer happens on the rising edge where both MemReq_o and
// MemGnt_i are high. For reads, the slave returns the word later with a
// one-cycle MemRValid_i pulse (never in the grant cycle itself); the master
// has no back-pressure on the read-return channel.
interface lsu_unit_if #(
    parameter int DATAWIDTH = 32
);
    logic                 MemReq_o;
    logic                 MemWe_o;
    logic [DATAWIDTH-1:0] MemAddr_o;
    logic [DATAWIDTH-1:0] MemWData_o;
    logic [3:0]           MemBe_o;
    logic                 MemGnt_i;
    logic                 MemRValid_i;
    logic [DATAWIDTH-1:0] MemRData_i;

    modport master (
        output MemReq_o, MemWe_o, MemAddr_o, MemWData_o, MemBe_o,
        input  MemGnt_i, MemRValid_i, MemRData_i
    );

    modport slave (
        input  MemReq_o, MemWe_o, MemAddr_o, MemWData_o, MemBe_o,
        output MemGnt_i, MemRValid_i, MemRData_i
    );
endinterface

// File: rtl/lsu_unit.sv
// Memory-stage load/store unit. Accepts one access at a time from execute,
// issues it on the word-organised memory bus, stalls the pipeline until the
// access completes and returns extended load data for writeback.
module lsu_unit #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 MemRead_i,
    input  logic                 MemWrite_i,
    input  logic [2:0]           Funct3_i,
    input  logic [DATAWIDTH-1:0] ALUResult_i,
    input  logic [DATAWIDTH-1:0] WriteData_i,
    input  logic [4:0]           Rd_i,
    output logic                 Stall_o,
    output logic                 LoadValid_o,
    output logic [DATAWIDTH-1:0] LoadData_o,
    output logic [4:0]           LoadRd_o,
    output logic                 Misaligned_o,
    lsu_unit_if.master           mem,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e state;

    // Access context captured at accept time, needed to format the load result.
    logic [2:0] lat_funct3;
    logic [1:0] lat_off;
    logic [4:0] lat_rd;

    logic                 req_present;
    logic                 is_load;
    logic                 funct3_ok;
    logic                 misaligned;
    logic                 accept;
    logic                 drop_misaligned;
    logic [3:0]           store_be;
    logic [DATAWIDTH-1:0] store_wdata;
    logic [7:0]           load_byte;
    logic [15:0]          load_half;
    logic [DATAWIDTH-1:0] load_ext;

    // Decode the execute-stage request: legality, alignment and whether to accept it.
    always_comb begin
        req_present = MemRead_i | MemWrite_i;
        // A load wins when both strobes are high.
        is_load     = MemRead_i;
        case (Funct3_i)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = is_load;
            default:                funct3_ok = 1'b0;
        endcase
        misaligned = ((Funct3_i[1:0] == 2'b01) && ALUResult_i[0]) ||
                     ((Funct3_i[1:0] == 2'b10) && (ALUResult_i[1:0] != 2'b00));
        accept          = (state == IDLE) && req_present && funct3_ok && !misaligned;
        drop_misaligned = (state == IDLE) && req_present && funct3_ok && misaligned;
    end

    // Replicate store data across lanes and pick byte enables from the low address bits.
    always_comb begin
        case (Funct3_i[1:0])
            2'b00: begin
                store_be    = 4'b0001 << ALUResult_i[1:0];
                store_wdata = {4{WriteData_i[7:0]}};
            end
            2'b01: begin
                store_be    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{WriteData_i[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = WriteData_i;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        case (lat_off)
            2'd0:    load_byte = mem.MemRData_i[7:0];
            2'd1:    load_byte = mem.MemRData_i[15:8];
            2'd2:    load_byte = mem.MemRData_i[23:16];
            default: load_byte = mem.MemRData_i[31:24];
        endcase
        load_half = lat_off[1] ? mem.MemRData_i[31:16] : mem.MemRData_i[15:0];
        case (lat_funct3)
            3'b000:  load_ext = {{(DATAWIDTH-8){load_byte[7]}}, load_byte};
            3'b100:  load_ext = {{(DATAWIDTH-8){1'b0}}, load_byte};
            3'b001:  load_ext = {{(DATAWIDTH-16){load_half[15]}}, load_half};
            3'b101:  load_ext = {{(DATAWIDTH-16){1'b0}}, load_half};
            default: load_ext = mem.MemRData_i;
        endcase
    end

    // Freeze upstream while a request is being accepted or one is in flight.
    assign Stall_o   = accept || (state != IDLE);
    assign dbg_state = state;

    // Transaction FSM: IDLE -> REQ (until grant) -> WAIT (loads, until rvalid) -> IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            lat_funct3     <= 3'b000;
            lat_off        <= 2'b00;
            lat_rd         <= 5'd0;
            LoadValid_o    <= 1'b0;
            LoadData_o     <= '0;
            LoadRd_o       <= 5'd0;
            Misaligned_o   <= 1'b0;
            mem.MemReq_o   <= 1'b0;
            mem.MemWe_o    <= 1'b0;
            mem.MemAddr_o  <= '0;
            mem.MemWData_o <= '0;
            mem.MemBe_o    <= 4'b0000;
        end else begin
            LoadValid_o  <= 1'b0;
            Misaligned_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_funct3     <= Funct3_i;
                        lat_off        <= ALUResult_i[1:0];
                        lat_rd         <= Rd_i;
                        mem.MemReq_o   <= 1'b1;
                        mem.MemWe_o    <= !is_load;
                        mem.MemAddr_o  <= {ALUResult_i[DATAWIDTH-1:2], 2'b00};
                        mem.MemBe_o    <= is_load ? 4'b1111 : store_be;
                        mem.MemWData_o <= is_load ? '0 : store_wdata;
                        state          <= REQ;
                    end else if (drop_misaligned) begin
                        Misaligned_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem.MemGnt_i) begin
                        mem.MemReq_o <= 1'b0;
                        state        <= mem.MemWe_o ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem.MemRValid_i) begin
                        LoadValid_o <= 1'b1;
                        LoadData_o  <= load_ext;
                        LoadRd_o    <= lat_rd;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: a driver issues accesses and plays the memory,
// expected bus requests / load results / misalignment pulses go into queues,
// and negedge monitors pop and compare whenever the unit presents an output.
module tb_lsu_unit;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          MemRead_i;
    logic          MemWrite_i;
    logic [2:0]    Funct3_i;
    logic [DW-1:0] ALUResult_i;
    logic [DW-1:0] WriteData_i;
    logic [4:0]    Rd_i;
    logic          Stall_o;
    logic          LoadValid_o;
    logic [DW-1:0] LoadData_o;
    logic [4:0]    LoadRd_o;
    logic          Misaligned_o;
    logic [1:0]    dbg_state;

    lsu_unit_if #(.DATAWIDTH(DW)) bus ();

    lsu_unit #(.DATAWIDTH(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .Funct3_i     (Funct3_i),
        .ALUResult_i  (ALUResult_i),
        .WriteData_i  (WriteData_i),
        .Rd_i         (Rd_i),
        .Stall_o      (Stall_o),
        .LoadValid_o  (LoadValid_o),
        .LoadData_o   (LoadData_o),
        .LoadRd_o     (LoadRd_o),
        .Misaligned_o (Misaligned_o),
        .mem          (bus),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    // request entry: {we, be[3:0], addr[31:0], wdata[31:0] (0 for reads)}
    logic [68:0] exp_req_q[$];
    // load entry: {rd[4:0], data[31:0], cycle of LoadValid_o}
    logic [68:0] exp_ld_q[$];
    // misalignment entry: cycle of the Misaligned_o pulse
    logic [31:0] exp_mis_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory request monitor: fields must match the head entry on every REQ cycle.
    logic [68:0] rq_act;
    always @(negedge clk) begin
        if (bus.MemReq_o) begin
            if (exp_req_q.size() == 0) begin
                check("mem_req_unexpected", 1, 0);
            end else begin
                rq_act = {bus.MemWe_o, bus.MemBe_o, bus.MemAddr_o,
                          bus.MemWe_o ? bus.MemWData_o : 32'h0};
                check("mem_req", rq_act, exp_req_q[0]);
                if (bus.MemGnt_i) void'(exp_req_q.pop_front());
            end
        end
    end

    // Load result monitor: data, rd and the cycle it appears in.
    logic [68:0] ld_exp;
    always @(negedge clk) begin
        if (LoadValid_o) begin
            if (exp_ld_q.size() == 0) begin
                check("load_unexpected", 1, 0);
            end else begin
                ld_exp = exp_ld_q.pop_front();
                check("load_result", {LoadRd_o, LoadData_o, 32'(cyc)}, ld_exp);
            end
        end
    end

    // Misalignment monitor: pulse must land in the predicted cycle.
    logic [31:0] mis_exp;
    always @(negedge clk) begin
        if (Misaligned_o) begin
            if (exp_mis_q.size() == 0) begin
                check("misaligned_unexpected", 1, 0);
            end else begin
                mis_exp = exp_mis_q.pop_front();
                check("misaligned_cycle", 32'(cyc), mis_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_pipe();
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        Funct3_i    = 3'b000;
        ALUResult_i = '0;
        WriteData_i = '0;
        Rd_i        = 5'd0;
    endtask

    // Called #1 after a rising edge. Presents one access, holds it until the
    // memory side completes, and plays the memory with the given delays:
    // grant gnt_dly cycles after the first REQ cycle, read data rv_dly cycles
    // after the grant. Returns #1 after the edge ending the last stall cycle.
    task automatic run_op(input string name, input logic rd_en, input logic wr_en,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                          input int exp_stall, input logic access, input logic mis,
                          input logic junk_rv);
        int stall_cnt;
        int last;
        stall_cnt   = 0;
        MemRead_i   = rd_en;
        MemWrite_i  = wr_en;
        Funct3_i    = f3;
        ALUResult_i = addr;
        WriteData_i = wd;
        Rd_i        = rd;
        if (mis) exp_mis_q.push_back(32'(cyc + 1));
        if (!access) begin
            @(negedge clk);
            if (Stall_o) stall_cnt++;
            @(posedge clk);
            #1;
        end else begin
            last = rd_en ? (1 + gnt_dly + rv_dly) : (1 + gnt_dly);
            for (int c = 0; c <= last; c++) begin
                bus.MemGnt_i    = (c == 1 + gnt_dly);
                bus.MemRValid_i = rd_en && ((c == last) || (junk_rv && c >= 1 && c <= gnt_dly));
                bus.MemRData_i  = (c == last) ? rdata : 32'hDEADBEEF;
                @(negedge clk);
                if (Stall_o) stall_cnt++;
                @(posedge clk);
                #1;
            end
            bus.MemGnt_i    = 1'b0;
            bus.MemRValid_i = 1'b0;
            bus.MemRData_i  = '0;
        end
        clear_pipe();
        check({name, "_stall_cycles"}, stall_cnt, exp_stall);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outputs"},
              {Stall_o, LoadValid_o, LoadData_o, LoadRd_o, Misaligned_o,
               bus.MemReq_o, bus.MemWe_o, bus.MemAddr_o, bus.MemWData_o, bus.MemBe_o}, 0);
        check({name, "_state"}, dbg_state, 2'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        clear_pipe();
        bus.MemGnt_i    = 1'b0;
        bus.MemRValid_i = 1'b0;
        bus.MemRData_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // SB lane 3, zero-wait grant
        exp_req_q.push_back({1'b1, 4'b1000, 32'h0000_1000, 32'hDDDD_DDDD});
        run_op("sb", 0, 1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 32'h0, 0, 0, 2, 1, 0, 0);

        // LB / LBU lane 2, zero-wait memory
        exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_2000, 32'h0});
        exp_ld_q.push_back({5'd7, 32'hFFFF_FFF4, 32'(cyc + 3)});
        run_op("lb", 1, 0, 3'b000, 32'h0000_2002, 32'h0, 5'd7, 32'h12F4_5678, 0, 1, 3, 1, 0, 0);
        exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_2000, 32'h0});
        exp_ld_q.push_back({5'd9, 32'h0000_00F4, 32'(cyc + 3)});
        run_op("lbu", 1, 0, 3'b100, 32'h0000_2002, 32'h0, 5'd9, 32'h12F4_5678, 0, 1, 3, 1, 0, 0);

        // LH upper half, grant 3 late, data 2 after grant, stray rvalid during REQ
        exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0004, 32'h0});
        exp_ld_q.push_back({5'd12, 32'hFFFF_8001, 32'(cyc + 7)});
        run_op("lh", 1, 0, 3'b001, 32'h0000_0006, 32'h0, 5'd12, 32'h8001_0000, 3, 2, 7, 1, 0, 1);

        // LW misaligned: dropped, pulse next cycle
        run_op("lw_mis", 1, 0, 3'b010, 32'h0000_0102, 32'h0, 5'd4, 32'h0, 0, 0, 0, 0, 1, 0);

        // SH upper half, grant 1 late
        exp_req_q.push_back({1'b1, 4'b1100, 32'h0000_0108, 32'hBEEF_BEEF});
        run_op("sh", 0, 1, 3'b001, 32'h0000_010A, 32'h1234_BEEF, 5'd0, 32'h0, 1, 0, 3, 1, 0, 0);

        // LHU upper half
        exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0000, 32'h0});
        exp_ld_q.push_back({5'd20, 32'h0000_9ABC, 32'(cyc + 3)});
        run_op("lhu", 1, 0, 3'b101, 32'h0000_0002, 32'h0, 5'd20, 32'h9ABC_1234, 0, 1, 3, 1, 0, 0);

        // LB lane 3 negative
        exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0000, 32'h0});
        exp_ld_q.push_back({5'd1, 32'hFFFF_FF80, 32'(cyc + 3)});
        run_op("lb3", 1, 0, 3'b000, 32'h0000_0003, 32'h0, 5'd1, 32'h80FF_FFFF, 0, 1, 3, 1, 0, 0);

        // Unsupported encodings: no access, no pulse, no stall
        run_op("ld_f3_011", 1, 0, 3'b011, 32'h0000_0000, 32'h0, 5'd2, 32'h0, 0, 0, 0, 0, 0, 0);
        run_op("st_f3_100", 0, 1, 3'b100, 32'h0000_0010, 32'h55, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0);

        // SW misaligned
        run_op("sw_mis", 0, 1, 3'b010, 32'h0000_0201, 32'h1, 5'd0, 32'h0, 0, 0, 0, 0, 1, 0);

        // Back-to-back: LW with both strobes high, then SW in the LoadValid cycle
        exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0300, 32'h0});
        exp_ld_q.push_back({5'd3, 32'hCAFE_BABE, 32'(cyc + 3)});
        run_op("lw_both", 1, 1, 3'b010, 32'h0000_0300, 32'h1111_1111, 5'd3, 32'hCAFE_BABE, 0, 1, 3, 1, 0, 0);
        exp_req_q.push_back({1'b1, 4'b1111, 32'h0000_0304, 32'h5A5A_1234});
        run_op("sw_b2b", 0, 1, 3'b010, 32'h0000_0304, 32'h5A5A_1234, 5'd0, 32'h0, 0, 0, 2, 1, 0, 0);

        // Reset in WAIT, then read data arrives: abandoned, no writeback
        exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0040, 32'h0});
        MemRead_i   = 1'b1;
        Funct3_i    = 3'b010;
        ALUResult_i = 32'h0000_0040;
        Rd_i        = 5'd5;
        @(posedge clk);
        #1;
        bus.MemGnt_i = 1'b1;
        @(posedge clk);
        #1;
        bus.MemGnt_i = 1'b0;
        rst = 1'b1;
        clear_pipe();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.MemRValid_i = 1'b1;
        bus.MemRData_i  = 32'h7777_7777;
        @(negedge clk);
        check_all_zero("rst_in_wait");
        @(posedge clk);
        #1;
        bus.MemRValid_i = 1'b0;
        @(negedge clk);
        check("rst_no_loadvalid", LoadValid_o, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("req_queue_drained", exp_req_q.size(), 0);
        check("load_queue_drained", exp_ld_q.size(), 0);
        check("mis_queue_drained", exp_mis_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
